// File: rtl/uid_auth_table.sv
// UID authorisation table: a small store of UIDs searched one entry per cycle,
// answering CHECK / ADD / DELETE / CLEAR commands with a one-cycle response strobe.
module uid_auth_table #(
    parameter int UID_MAX = 8,
    parameter int UID_LEN = 4,
    localparam int IDX_W = $clog2(UID_MAX),
    localparam int CNT_W = $clog2(UID_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd,
    input  logic [8*UID_LEN-1:0] uid_in,
    output logic                 rsp_valid,
    output logic [3:0]           rsp_code,
    output logic [IDX_W-1:0]     rsp_index,
    output logic [CNT_W-1:0]     uid_count,
    output logic                 uid_full,
    output logic                 uid_empty
);

    localparam logic [7:0] OP_CHECK  = 8'h10;
    localparam logic [7:0] OP_ADD    = 8'h11;
    localparam logic [7:0] OP_DELETE = 8'h12;
    localparam logic [7:0] OP_CLEAR  = 8'h13;

    localparam logic [3:0] RC_ALLOWED   = 4'h1;
    localparam logic [3:0] RC_DENIED    = 4'h2;
    localparam logic [3:0] RC_ADDED     = 4'h3;
    localparam logic [3:0] RC_DUPLICATE = 4'h4;
    localparam logic [3:0] RC_FULL      = 4'h5;
    localparam logic [3:0] RC_DELETED   = 4'h6;
    localparam logic [3:0] RC_NOT_FOUND = 4'h7;
    localparam logic [3:0] RC_CLEARED   = 4'h8;
    localparam logic [3:0] RC_BAD_CMD   = 4'hF;

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    state_t               state, state_nx;
    logic [7:0]           cmd_q;
    logic [8*UID_LEN-1:0] uid_q;
    logic                 pend_q;      // accepted CLEAR/unknown opcode waiting one cycle for RESP
    logic [IDX_W-1:0]     scan_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;

    logic [8*UID_LEN-1:0] data_mem [UID_MAX];
    logic [UID_MAX-1:0]   valid;

    logic                 accept, is_scan, hit, last, free_now, done;
    logic [IDX_W-1:0]     free_idx_now, idx_nx;
    logic [3:0]           code_nx;
    logic                 add_en, del_en, clr_en;

    assign cmd_ready = (state == IDLE) && !pend_q;
    assign accept    = cmd_valid && cmd_ready;
    assign is_scan   = (cmd == OP_CHECK) || (cmd == OP_ADD) || (cmd == OP_DELETE);

    assign hit          = valid[scan_idx] && (data_mem[scan_idx] == uid_q);
    assign last         = (scan_idx == IDX_W'(UID_MAX - 1));
    assign free_now     = free_found || !valid[scan_idx];
    assign free_idx_now = free_found ? free_idx : scan_idx;

    assign uid_full  = (uid_count == CNT_W'(UID_MAX));
    assign uid_empty = (uid_count == '0);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        code_nx  = RC_BAD_CMD;
        idx_nx   = '0;
        add_en   = 1'b0;
        del_en   = 1'b0;
        clr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_q) begin
                    done = 1'b1;
                    if (cmd_q == OP_CLEAR) begin
                        code_nx = RC_CLEARED;
                        clr_en  = 1'b1;
                    end
                end else if (accept && is_scan) begin
                    state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (hit || last) begin
                    done = 1'b1;
                    case (cmd_q)
                        OP_CHECK: begin
                            code_nx = hit ? RC_ALLOWED : RC_DENIED;
                            idx_nx  = hit ? scan_idx : '0;
                        end
                        OP_ADD: begin
                            if (hit) begin
                                code_nx = RC_DUPLICATE;
                                idx_nx  = scan_idx;
                            end else if (free_now) begin
                                code_nx = RC_ADDED;
                                idx_nx  = free_idx_now;
                                add_en  = 1'b1;
                            end else begin
                                code_nx = RC_FULL;
                            end
                        end
                        OP_DELETE: begin
                            code_nx = hit ? RC_DELETED : RC_NOT_FOUND;
                            idx_nx  = hit ? scan_idx : '0;
                            del_en  = hit;
                        end
                        default: code_nx = RC_BAD_CMD;
                    endcase
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (done) state_nx = RESP;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_q      <= '0;
            uid_q      <= '0;
            pend_q     <= 1'b0;
            scan_idx   <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cmd_q      <= cmd;
                uid_q      <= uid_in;
                pend_q     <= !is_scan;
                scan_idx   <= '0;
                free_found <= 1'b0;
            end else if (pend_q) begin
                pend_q <= 1'b0;
            end else if (state == SEARCH && !done) begin
                scan_idx <= scan_idx + 1'b1;
                if (!free_found && !valid[scan_idx]) begin
                    free_found <= 1'b1;
                    free_idx   <= scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= '0;
            uid_count <= '0;
            rsp_valid <= 1'b0;
            rsp_code  <= 4'h0;
            rsp_index <= '0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_code  <= code_nx;
                rsp_index <= idx_nx;
            end
            if (clr_en) begin
                valid     <= '0;
                uid_count <= '0;
            end else if (add_en) begin
                valid[free_idx_now] <= 1'b1;
                uid_count           <= uid_count + 1'b1;
            end else if (del_en) begin
                valid[scan_idx] <= 1'b0;
                uid_count       <= uid_count - 1'b1;
            end
        end
    end

    // NOTE: UID bytes are not reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (add_en) data_mem[free_idx_now] <= uid_q;
    end

endmodule

// File: tb/tb_uid_auth_table.sv
// Bench for uid_auth_table: directed scenarios then random commands, all checked
// against an array-based reference table kept in the bench.
module tb_uid_auth_table;

    localparam int UID_MAX = 8;
    localparam int UID_LEN = 4;
    localparam int IDX_W   = $clog2(UID_MAX);
    localparam int CNT_W   = $clog2(UID_MAX + 1);
    localparam int LAT_MAX = 2 * UID_MAX + 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [7:0]           cmd = 8'h00;
    logic [8*UID_LEN-1:0] uid_in = '0;
    logic                 rsp_valid;
    logic [3:0]           rsp_code;
    logic [IDX_W-1:0]     rsp_index;
    logic [CNT_W-1:0]     uid_count;
    logic                 uid_full;
    logic                 uid_empty;

    int compared = 0;
    int mismatched = 0;

    // reference table
    bit          m_valid [UID_MAX];
    logic [31:0] m_data  [UID_MAX];
    logic [31:0] pool    [12];

    uid_auth_table #(.UID_MAX(UID_MAX), .UID_LEN(UID_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .uid_in(uid_in), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .rsp_index(rsp_index), .uid_count(uid_count), .uid_full(uid_full),
        .uid_empty(uid_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < UID_MAX; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < UID_MAX; i++) m_valid[i] = 0;
    endfunction

    // Predicts code/index/latency from the table rules and applies the table update.
    task automatic model_cmd(input logic [7:0] op, input logic [31:0] uid,
                             output logic [3:0] e_code, output int e_idx, output int e_lat);
        int h = -1;
        int f = -1;
        for (int i = UID_MAX - 1; i >= 0; i--) begin
            if (m_valid[i] && m_data[i] == uid) h = i;
            if (!m_valid[i]) f = i;
        end
        e_idx = 0;
        e_lat = (h >= 0) ? h + 1 : UID_MAX;
        case (op)
            8'h10: begin e_code = (h >= 0) ? 4'h1 : 4'h2; if (h >= 0) e_idx = h; end
            8'h11: begin
                if (h >= 0) begin e_code = 4'h4; e_idx = h; end
                else if (f >= 0) begin e_code = 4'h3; e_idx = f; m_valid[f] = 1; m_data[f] = uid; end
                else e_code = 4'h5;
            end
            8'h12: begin
                if (h >= 0) begin e_code = 4'h6; e_idx = h; m_valid[h] = 0; end
                else e_code = 4'h7;
            end
            8'h13: begin e_code = 4'h8; e_lat = 1; model_clear(); end
            default: begin e_code = 4'hF; e_lat = 1; end
        endcase
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] uid);
        logic [3:0] e_code;
        int e_idx, e_lat, lat, guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < LAT_MAX) begin @(negedge clk); guard++; end
        check({tag, ".ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd       = op;
        uid_in    = uid;
        model_cmd(op, uid, e_code, e_idx, e_lat);
        @(posedge clk); #1;
        check({tag, ".busy"}, cmd_ready, 0);
        // keep requesting with garbage while busy: must be ignored, operands already latched
        cmd    = 8'h11;
        uid_in = $urandom;
        lat    = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < LAT_MAX);
        cmd_valid = 1'b0;
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".code"}, rsp_code, e_code);
        check({tag, ".index"}, rsp_index, e_idx);
        check({tag, ".count"}, uid_count, model_count());
        check({tag, ".full"}, uid_full, model_count() == UID_MAX);
        check({tag, ".empty"}, uid_empty, model_count() == 0);
        @(posedge clk); #1;
        check({tag, ".strobe_1cyc"}, rsp_valid, 0);
        check({tag, ".code_hold"}, rsp_code, e_code);
    endtask

    initial begin
        logic [31:0] u, ghost;
        logic [7:0]  op;
        bit          saw_rsp;
        int          r;
        model_clear();
        for (int i = 0; i < 12; i++) pool[i] = $urandom;

        // reset state
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_code", rsp_code, 0);
        check("rst.rsp_index", rsp_index, 0);
        check("rst.count", uid_count, 0);
        check("rst.empty", uid_empty, 1);
        check("rst.full", uid_full, 0);
        check("rst.ready", cmd_ready, 1);

        // miss on empty table, then add and duplicate
        run_cmd("chk_empty", 8'h10, 32'hDEADBEEF);
        run_cmd("add_first", 8'h11, 32'hDEADBEEF);
        run_cmd("add_dup", 8'h11, 32'hDEADBEEF);

        // fill the table, overflow, duplicate beats full
        run_cmd("clr0", 8'h13, 32'h0);
        for (int i = 0; i < UID_MAX; i++) run_cmd("fill", 8'h11, 32'h1000_0000 + 32'(i * 17));
        run_cmd("add_full", 8'h11, 32'hCAFE0009);
        run_cmd("dup_over_full", 8'h11, 32'h1000_0000 + 32'(5 * 17));

        // delete slot 3 and reuse it
        run_cmd("del3", 8'h12, 32'h1000_0000 + 32'(3 * 17));
        run_cmd("reuse3", 8'h11, 32'hCAFE000A);
        run_cmd("chk_deleted", 8'h10, 32'h1000_0000 + 32'(3 * 17));
        run_cmd("chk_hit7", 8'h10, 32'h1000_0000 + 32'(7 * 17));

        // last byte must participate in the compare
        run_cmd("chk_lastbyte", 8'h10, (32'h1000_0000 + 32'(2 * 17)) ^ 32'h0100_0000);
        run_cmd("clear", 8'h13, 32'h0);
        run_cmd("bad_cmd", 8'h55, 32'h0);

        // reset in the middle of an ADD search
        ghost = 32'h0BADF00D;
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 8'h11; uid_in = ghost;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_mid.rsp_valid", rsp_valid, 0);
        #1 rst_n = 1'b1;
        saw_rsp = 0;
        for (int i = 0; i < UID_MAX + 2; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw_rsp = 1;
        end
        check("rst_mid.no_rsp", saw_rsp, 0);
        check("rst_mid.count", uid_count, 0);
        check("rst_mid.ready", cmd_ready, 1);
        model_clear();
        run_cmd("rst_mid.chk", 8'h10, ghost);

        // random traffic over a small UID pool so hits, deletes and overflow all occur
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 19);
            u = pool[$urandom_range(0, 11)];
            if (r < 6)       op = 8'h10;
            else if (r < 13) op = 8'h11;
            else if (r < 18) op = 8'h12;
            else if (r < 19) op = 8'h13;
            else             op = 8'(8'h20 + $urandom_range(0, 200));
            if (r == 5) u = u ^ 32'h0000_0100;
            run_cmd("rand", op, u);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
